// File: rtl/lsu_pkg.sv
// Shared load/store definitions for the memory stage: funct3 encodings and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper: store enables/replication and access fault detection on the
// request side, byte/half extraction with sign/zero extension on the response side.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_store_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_fault,
    input  logic [2:0]  i_rsp_funct3,
    input  logic [1:0]  i_rsp_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    logic [31:0] shifted;

    // Request side: lane enables, replicated write data and misalignment/illegal checks.
    always_comb begin
        o_be    = '0;
        o_wdata = '0;
        o_fault = 1'b0;
        if (i_is_store) begin
            case (i_funct3)
                F3_SB: begin
                    o_be    = 4'b0001 << i_off;
                    o_wdata = {4{i_store_data[7:0]}};
                end
                F3_SH: begin
                    o_be    = 4'b0011 << i_off;
                    o_wdata = {2{i_store_data[15:0]}};
                    o_fault = i_off[0];
                end
                F3_SW: begin
                    o_be    = 4'b1111;
                    o_wdata = i_store_data;
                    o_fault = |i_off;
                end
                default: o_fault = 1'b1;
            endcase
        end else if (i_is_load) begin
            o_be = 4'b1111;
            case (i_funct3)
                F3_LB, F3_LBU: o_fault = 1'b0;
                F3_LH, F3_LHU: o_fault = i_off[0];
                F3_LW:         o_fault = |i_off;
                default:       o_fault = 1'b1;
            endcase
        end
    end

    // Response side: shift the addressed lane down, then extend to 32 bits.
    always_comb begin
        shifted = i_rdata >> {i_rsp_off, 3'b000};
        case (i_rsp_funct3)
            F3_LB:   o_load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  o_load_data = {24'b0, shifted[7:0]};
            F3_LH:   o_load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  o_load_data = {16'b0, shifted[15:0]};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// RV32I memory stage: single-cycle pass-through for non-memory ops, request/response
// FSM for loads and stores with stall, alignment, fault and response timeout.
module stage_mem
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_rd_wen,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd_addr,
    output logic        o_wb_rd_wen,
    output logic        o_mem_fault,
    output logic        o_mem_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    mem_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d, rd_wen_q, rd_wen_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        wb_valid_q, wb_valid_d, wb_rd_wen_q, wb_rd_wen_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
    logic        fault_q, fault_d, err_q, err_d;

    logic        is_mem;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load_data;
    logic        al_fault;

    assign is_mem = i_valid & (i_mem_rd | i_mem_wr);

    lsu_align u_align (
        .i_is_load    (i_mem_rd),
        .i_is_store   (i_mem_wr),
        .i_funct3     (i_funct3),
        .i_off        (i_alu_result[1:0]),
        .i_store_data (i_store_data),
        .o_be         (al_be),
        .o_wdata      (al_wdata),
        .o_fault      (al_fault),
        .i_rsp_funct3 (f3_q),
        .i_rsp_off    (addr_q[1:0]),
        .i_rdata      (i_dmem_rdata),
        .o_load_data  (al_load_data)
    );

    // Next-state, latched request fields, WB payload and combinational stall/request.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        f3_d         = f3_q;
        we_d         = we_q;
        rd_addr_d    = rd_addr_q;
        rd_wen_d     = rd_wen_q;
        wb_valid_d   = 1'b0;
        wb_data_d    = wb_data_q;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_rd_wen_d  = 1'b0;
        fault_d      = 1'b0;
        err_d        = 1'b0;
        o_stall      = 1'b0;
        o_dmem_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem && al_fault) begin
                    wb_valid_d   = 1'b1;
                    wb_data_d    = i_alu_result;
                    wb_rd_addr_d = i_rd_addr;
                    fault_d      = 1'b1;
                end else if (is_mem) begin
                    o_stall   = 1'b1;
                    state_d   = ST_REQ;
                    addr_d    = i_alu_result;
                    wdata_d   = al_wdata;
                    be_d      = al_be;
                    f3_d      = i_funct3;
                    we_d      = i_mem_wr;
                    rd_addr_d = i_rd_addr;
                    rd_wen_d  = i_rd_wen;
                end else begin
                    wb_valid_d   = i_valid;
                    wb_data_d    = i_alu_result;
                    wb_rd_addr_d = i_rd_addr;
                    wb_rd_wen_d  = i_valid & i_rd_wen;
                end
            end
            ST_REQ: begin
                o_dmem_req = 1'b1;
                o_stall    = 1'b1;
                if (i_dmem_ready && we_q) begin
                    o_stall      = 1'b0;
                    state_d      = ST_IDLE;
                    wb_valid_d   = 1'b1;
                    wb_data_d    = addr_q;
                    wb_rd_addr_d = rd_addr_q;
                end else if (i_dmem_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (i_dmem_rvalid) begin
                    state_d      = ST_IDLE;
                    wb_valid_d   = 1'b1;
                    wb_data_d    = al_load_data;
                    wb_rd_addr_d = rd_addr_q;
                    wb_rd_wen_d  = rd_wen_q;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d      = ST_IDLE;
                    err_d        = 1'b1;
                    wb_valid_d   = 1'b1;
                    wb_data_d    = '0;
                    wb_rd_addr_d = rd_addr_q;
                end else begin
                    o_stall = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; async reset drops any outstanding request at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            f3_q         <= '0;
            we_q         <= 1'b0;
            rd_addr_q    <= '0;
            rd_wen_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_addr_q <= '0;
            wb_rd_wen_q  <= 1'b0;
            fault_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            f3_q         <= f3_d;
            we_q         <= we_d;
            rd_addr_q    <= rd_addr_d;
            rd_wen_q     <= rd_wen_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_rd_wen_q  <= wb_rd_wen_d;
            fault_q      <= fault_d;
            err_q        <= err_d;
        end
    end

    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = {addr_q[31:2], 2'b00};
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_be    = be_q;
    assign o_wb_valid   = wb_valid_q;
    assign o_wb_data    = wb_data_q;
    assign o_wb_rd_addr = wb_rd_addr_q;
    assign o_wb_rd_wen  = wb_rd_wen_q;
    assign o_mem_fault  = fault_q;
    assign o_mem_err    = err_q;

endmodule

// File: tb/tb_stage_mem.sv
// Directed + randomized bench for stage_mem with a byte-lane reference model.
module tb_stage_mem;

    localparam int unsigned TO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic        i_mem_rd;
    logic        i_mem_wr;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_addr;
    logic        i_rd_wen;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd_addr;
    logic        o_wb_rd_wen;
    logic        o_mem_fault;
    logic        o_mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    stage_mem #(.TIMEOUT_CYC(TO)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_alu_result  (i_alu_result),
        .i_store_data  (i_store_data),
        .i_mem_rd      (i_mem_rd),
        .i_mem_wr      (i_mem_wr),
        .i_funct3      (i_funct3),
        .i_rd_addr     (i_rd_addr),
        .i_rd_wen      (i_rd_wen),
        .o_stall       (o_stall),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_be     (o_dmem_be),
        .i_dmem_ready  (i_dmem_ready),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_wb_valid    (o_wb_valid),
        .o_wb_data     (o_wb_data),
        .o_wb_rd_addr  (o_wb_rd_addr),
        .o_wb_rd_wen   (o_wb_rd_wen),
        .o_mem_fault   (o_mem_fault),
        .o_mem_err     (o_mem_err)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model (size/offset arithmetic) ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_fault(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (!ld && f3 > 3'd2) return 1'b1;
        return (a % 4) % m_size(f3) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v;
        v = ((1 << m_size(f3)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % m_size(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint unsigned v, span;
        int unsigned sz;
        sz = m_size(f3);
        if (sz == 4) return rd;
        span = 64'd1 << (8 * sz);
        v = (longint'(rd) >> (8 * (a % 4))) % span;
        if (f3[2] == 1'b0 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid       = 1'b0;
        i_mem_rd      = 1'b0;
        i_mem_wr      = 1'b0;
        i_rd_wen      = 1'b0;
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
    endtask

    task automatic run_alu(input logic [31:0] res, input logic [4:0] rd);
        i_valid = 1'b1; i_mem_rd = 1'b0; i_mem_wr = 1'b0;
        i_alu_result = res; i_rd_addr = rd; i_rd_wen = 1'b1;
        i_funct3 = 3'($urandom_range(0, 7));
        @(negedge i_clk);
        chk("alu_stall", o_stall, 0);
        chk("alu_req", o_dmem_req, 0);
        tick();
        idle_inputs();
        chk("alu_wb_valid", o_wb_valid, 1);
        chk("alu_wb_data", o_wb_data, res);
        chk("alu_wb_rd", o_wb_rd_addr, rd);
        chk("alu_wb_wen", o_wb_rd_wen, 1);
    endtask

    task automatic run_mem(input bit ld, input logic [31:0] a, input logic [31:0] sd,
                           input logic [2:0] f3, input logic [31:0] rdata, input logic [4:0] rd,
                           input int unsigned rdy_dly, input int unsigned rv_dly);
        bit last;
        i_valid = 1'b1; i_mem_rd = ld; i_mem_wr = !ld;
        i_alu_result = a; i_store_data = sd; i_funct3 = f3;
        i_rd_addr = rd; i_rd_wen = ld;
        if (m_fault(ld, f3, a)) begin
            @(negedge i_clk);
            chk("flt_stall", o_stall, 0);
            chk("flt_req", o_dmem_req, 0);
            tick();
            idle_inputs();
            chk("flt_pulse", o_mem_fault, 1);
            chk("flt_wb_valid", o_wb_valid, 1);
            chk("flt_wb_wen", o_wb_rd_wen, 0);
            tick();
            chk("flt_pulse_end", o_mem_fault, 0);
            chk("flt_req_after", o_dmem_req, 0);
        end else begin
            @(negedge i_clk);
            chk("idle_stall", o_stall, 1);
            chk("idle_req", o_dmem_req, 0);
            tick();
            chk("req_wb_quiet", o_wb_valid, 0);
            for (int unsigned k = 0; k <= rdy_dly; k++) begin
                last = (k == rdy_dly);
                i_dmem_ready = last;
                @(negedge i_clk);
                chk("req_valid", o_dmem_req, 1);
                chk("req_addr", o_dmem_addr, {a[31:2], 2'b00});
                chk("req_we", o_dmem_we, !ld);
                if (!ld) begin
                    chk("req_be", o_dmem_be, m_be(f3, a));
                    chk("req_wdata", o_dmem_wdata, m_wdata(f3, sd));
                end
                chk("req_stall", o_stall, ld ? 1'b1 : !last);
                tick();
                i_dmem_ready = 1'b0;
            end
            if (!ld) begin
                idle_inputs();
                chk("st_wb_valid", o_wb_valid, 1);
                chk("st_wb_wen", o_wb_rd_wen, 0);
            end else begin
                for (int unsigned k = 0; k <= rv_dly; k++) begin
                    last = (k == rv_dly);
                    i_dmem_rvalid = last;
                    i_dmem_rdata  = last ? rdata : $urandom;
                    @(negedge i_clk);
                    chk("wait_stall", o_stall, !last);
                    chk("wait_req", o_dmem_req, 0);
                    tick();
                    i_dmem_rvalid = 1'b0;
                    if (!last) chk("wait_wb_quiet", o_wb_valid, 0);
                end
                idle_inputs();
                chk("ld_wb_valid", o_wb_valid, 1);
                chk("ld_wb_data", o_wb_data, m_load(f3, a, rdata));
                chk("ld_wb_rd", o_wb_rd_addr, rd);
                chk("ld_wb_wen", o_wb_rd_wen, 1);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_rst_n = 1'b0;
        idle_inputs();
        i_alu_result = '0; i_store_data = '0; i_funct3 = '0; i_rd_addr = '0;
        i_dmem_rdata = '0;
        #2;
        chk("rst_req", o_dmem_req, 0);
        chk("rst_be", o_dmem_be, 0);
        chk("rst_addr", o_dmem_addr, 0);
        chk("rst_wb_valid", o_wb_valid, 0);
        chk("rst_wb_data", o_wb_data, 0);
        chk("rst_fault", o_mem_fault, 0);
        chk("rst_err", o_mem_err, 0);
        #10 i_rst_n = 1'b1;
        tick();

        // directed cases
        run_alu(32'h1234_5678, 5'd5);
        run_mem(0, 32'h0000_0103, 32'h0000_00AB, 3'b000, '0, 5'd0, 2, 0);
        run_mem(1, 32'h0000_0102, '0, 3'b000, 32'h0080_0000, 5'd7, 0, 0);
        run_mem(1, 32'h0000_0102, '0, 3'b100, 32'h0080_0000, 5'd8, 0, 1);
        run_mem(1, 32'h0000_0102, '0, 3'b101, 32'hBEEF_0000, 5'd9, 1, 2);
        run_mem(1, 32'h0000_0101, '0, 3'b010, '0, 5'd10, 0, 0);
        run_mem(1, 32'h0000_0100, '0, 3'b011, '0, 5'd11, 0, 0);
        run_mem(0, 32'h0000_0202, 32'hCAFE_1234, 3'b001, '0, 5'd0, 0, 0);

        // response timeout
        i_valid = 1'b1; i_mem_rd = 1'b1; i_alu_result = 32'h200; i_funct3 = 3'b010;
        i_rd_addr = 5'd12; i_rd_wen = 1'b1; i_dmem_ready = 1'b1;
        tick();
        tick();
        i_dmem_ready = 1'b0;
        for (int unsigned k = 0; k < TO; k++) begin
            @(negedge i_clk);
            chk("to_stall", o_stall, k != TO - 1);
            tick();
            if (k < TO - 1) chk("to_err_quiet", o_mem_err, 0);
        end
        idle_inputs();
        chk("to_err", o_mem_err, 1);
        chk("to_wb_valid", o_wb_valid, 1);
        chk("to_wb_data", o_wb_data, 0);
        chk("to_wb_wen", o_wb_rd_wen, 0);
        tick();
        chk("to_err_end", o_mem_err, 0);
        run_alu(32'h0BAD_F00D, 5'd3);

        // reset while a request is outstanding
        i_valid = 1'b1; i_mem_rd = 1'b1; i_alu_result = 32'h304; i_funct3 = 3'b010;
        i_rd_addr = 5'd13; i_rd_wen = 1'b1;
        tick();
        @(negedge i_clk);
        chk("pre_rst_req", o_dmem_req, 1);
        #2 i_rst_n = 1'b0; idle_inputs();
        #1;
        chk("rst_req_drop", o_dmem_req, 0);
        chk("rst_req_stall", o_stall, 0);
        #1 i_rst_n = 1'b1;
        tick();

        // reset during WAIT, then a stale response
        i_valid = 1'b1; i_mem_rd = 1'b1; i_alu_result = 32'h408; i_funct3 = 3'b010;
        i_rd_addr = 5'd14; i_rd_wen = 1'b1; i_dmem_ready = 1'b1;
        tick();
        tick();
        i_dmem_ready = 1'b0;
        @(negedge i_clk);
        chk("pre_rst_wait_stall", o_stall, 1);
        #2 i_rst_n = 1'b0; idle_inputs();
        #1;
        chk("rstw_req", o_dmem_req, 0);
        chk("rstw_stall", o_stall, 0);
        chk("rstw_addr", o_dmem_addr, 0);
        chk("rstw_wb_valid", o_wb_valid, 0);
        #1 i_rst_n = 1'b1;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("stale_wb_valid", o_wb_valid, 0);
        tick();
        i_dmem_rvalid = 1'b0;
        chk("stale_wb_valid2", o_wb_valid, 0);
        chk("stale_wb_wen", o_wb_rd_wen, 0);

        // randomized mix, back-to-back
        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = $urandom;
            if (kind == 0)
                run_alu($urandom, 5'($urandom_range(1, 31)));
            else if (kind == 1)
                run_mem(1, a, '0, 3'($urandom_range(0, 7)), $urandom,
                        5'($urandom_range(1, 31)), $urandom_range(0, 2), $urandom_range(0, 3));
            else
                run_mem(0, a, $urandom, 3'($urandom_range(0, 3)), '0, 5'd0,
                        $urandom_range(0, 2), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
